// File: rtl/axis_out_pack.sv
// axis_out_pack: truncates each row of a shifter beat to Y_OUT_BITS, gear-boxes
// consecutive beats into AXI_WIDTH-bit words with byte keep, forwards packet end
// as tlast and flags (sticky) any transfer whose byte count disagrees with the
// shifter's bytes-per-transfer value.
module axis_out_pack #(
   parameter int ROWS       = 4,
   parameter int Y_BITS     = 32,
   parameter int Y_OUT_BITS = 8,
   parameter int AXI_WIDTH  = 64,
   parameter int W_BPT      = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [ROWS*Y_BITS-1:0]   s_data,
   input  logic                     s_last,
   input  logic                     s_last_pkt,
   input  logic [W_BPT-1:0]         s_bytes_per_transfer,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [AXI_WIDTH-1:0]     m_data,
   output logic [AXI_WIDTH/8-1:0]   m_keep,
   output logic                     m_last,
   output logic                     err_bpt
);

   localparam int P      = ROWS * Y_OUT_BITS;
   localparam int BEATS  = AXI_WIDTH / P;
   localparam int BPB    = P / 8;
   localparam int KEEP_W = AXI_WIDTH / 8;
   localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Keep only the low Y_OUT_BITS of every row; wrap-around truncation, no saturation.
   function automatic logic [P-1:0] trunc_beat(input logic [ROWS*Y_BITS-1:0] d);
      logic [P-1:0] r;
      r = '0;
      for (int i = 0; i < ROWS; i++) begin
         r[i*Y_OUT_BITS +: Y_OUT_BITS] = d[i*Y_BITS +: Y_OUT_BITS];
      end
      return r;
   endfunction

   // Byte enables for a word whose highest filled lane is i.
   function automatic logic [KEEP_W-1:0] keep_for(input logic [IDX_W-1:0] i);
      logic [KEEP_W-1:0] k;
      k = '0;
      for (int b = 0; b < KEEP_W; b++) begin
         if (b < (int'(i) + 1) * BPB) k[b] = 1'b1;
      end
      return k;
   endfunction

   logic [IDX_W-1:0]      idx;
   logic [W_BPT-1:0]      cnt;
   logic [AXI_WIDTH-1:0]  asm_buf_p1;
   logic [P-1:0]          beat_p0;
   logic [AXI_WIDTH-1:0]  word_p0;
   logic                  acc_p0;
   logic                  xfer_end_p0;
   logic                  done_p0;
   logic [W_BPT-1:0]      cnt_sum_p0;
   logic                  unused_s_data_hi;

   // High row bits are dropped by design.
   assign unused_s_data_hi = ^s_data;

   // ---- input stage: accept, truncate, decide word completion
   assign s_ready     = !m_valid || m_ready;
   assign acc_p0      = s_valid && s_ready;
   assign beat_p0     = trunc_beat(s_data);
   assign xfer_end_p0 = s_last || s_last_pkt;
   assign done_p0     = acc_p0 && ((idx == IDX_W'(BEATS - 1)) || xfer_end_p0);
   assign cnt_sum_p0  = cnt + W_BPT'(BPB);

   // Completed word = assembly buffer with the current beat dropped into lane idx.
   always_comb begin
      word_p0 = asm_buf_p1;
      word_p0[int'(idx)*P +: P] = beat_p0;
   end

   // Lane index and assembly buffer; buffer is cleared whenever a word leaves it.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         idx        <= '0;
         asm_buf_p1 <= '0;
      end else if (acc_p0) begin
         if (done_p0) begin
            idx        <= '0;
            asm_buf_p1 <= '0;
         end else begin
            idx                            <= idx + IDX_W'(1);
            asm_buf_p1[int'(idx)*P +: P]   <= beat_p0;
         end
      end
   end

   // ---- output stage: register completed word, hold it until the handshake
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_keep  <= '0;
         m_last  <= 1'b0;
      end else if (done_p0) begin
         m_valid <= 1'b1;
         m_data  <= word_p0;
         m_keep  <= keep_for(idx);
         m_last  <= s_last_pkt;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

   // Transfer byte counter; the expected count is only looked at on the closing beat.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt     <= '0;
         err_bpt <= 1'b0;
      end else if (acc_p0) begin
         if (xfer_end_p0) begin
            cnt <= '0;
            if (cnt_sum_p0 != s_bytes_per_transfer) err_bpt <= 1'b1;
         end else begin
            cnt <= cnt_sum_p0;
         end
      end
   end

endmodule

// File: tb/tb_axis_out_pack.sv
// Bench for axis_out_pack: directed scenarios plus randomized transfers against
// a queue-based reference model of the packing and byte-count rules.
module tb_axis_out_pack;

   localparam int ROWS = 4, Y_BITS = 32, Y_OUT_BITS = 8, AXI_WIDTH = 64, W_BPT = 16;
   localparam int BEATS = 2, BPB = 4;

   logic          aclk;
   logic          aresetn;
   logic          s_valid;
   logic          s_ready;
   logic [127:0]  s_data;
   logic          s_last;
   logic          s_last_pkt;
   logic [15:0]   s_bytes_per_transfer;
   logic          m_valid;
   logic          m_ready;
   logic [63:0]   m_data;
   logic [7:0]    m_keep;
   logic          m_last;
   logic          err_bpt;

   axis_out_pack #(
      .ROWS(ROWS), .Y_BITS(Y_BITS), .Y_OUT_BITS(Y_OUT_BITS),
      .AXI_WIDTH(AXI_WIDTH), .W_BPT(W_BPT)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .s_last_pkt(s_last_pkt),
      .s_bytes_per_transfer(s_bytes_per_transfer),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_keep(m_keep), .m_last(m_last), .err_bpt(err_bpt)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model
   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } word_t;

   word_t        exp_q[$];
   logic [31:0]  part_q[$];
   int unsigned  xfer_bytes = 0;
   logic         exp_err = 1'b0;

   task automatic model_reset();
      exp_q.delete();
      part_q.delete();
      xfer_bytes = 0;
      exp_err    = 1'b0;
   endtask

   task automatic model_accept(input logic [127:0] d, input logic last, input logic lpkt,
                               input logic [15:0] bpt);
      logic [31:0] pay;
      word_t       w;
      for (int r = 0; r < ROWS; r++) pay[r*8 +: 8] = d[r*32 +: 8];
      part_q.push_back(pay);
      xfer_bytes += BPB;
      if (part_q.size() == BEATS || last || lpkt) begin
         w.data = '0;
         for (int i = 0; i < part_q.size(); i++) w.data |= 64'(part_q[i]) << (32 * i);
         w.keep = 8'((1 << (BPB * part_q.size())) - 1);
         w.last = lpkt;
         exp_q.push_back(w);
         part_q.delete();
      end
      if (last || lpkt) begin
         if ((xfer_bytes % 65536) != int'(bpt)) exp_err = 1'b1;
         xfer_bytes = 0;
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   // ---------------- driver
   bit rdy_rand = 0;

   task automatic send(input logic [127:0] d, input logic last, input logic lpkt,
                       input logic [15:0] bpt);
      bit acc = 0;
      s_data = d; s_last = last; s_last_pkt = lpkt; s_bytes_per_transfer = bpt; s_valid = 1'b1;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge aclk);
         acc = s_ready;
         @(posedge aclk);
         #1;
      end
      s_valid = 1'b0; s_last = 1'b0; s_last_pkt = 1'b0;
      if (acc) model_accept(d, last, lpkt, bpt);
      else     chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      rdy_rand = 0;
      m_ready  = 1'b1;
      for (int t = 0; t < 30; t++) begin
         @(negedge aclk);
         if (exp_q.size() == 0 && !m_valid) break;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge aclk); #1;
   endtask

   always @(posedge aclk) begin
      #1;
      if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- monitor
   word_t        mon_w;
   bit           hold_v = 0;
   logic [63:0]  hold_d;
   logic [7:0]   hold_k;
   logic         hold_l;

   always @(negedge aclk) begin
      if (aresetn) begin
         chk("s_ready", 64'(s_ready), 64'(!m_valid || m_ready));
         chk("err_bpt", 64'(err_bpt), 64'(exp_err));
         if (hold_v) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_data",  m_data, hold_d);
            chk("hold_keep",  64'(m_keep), 64'(hold_k));
            chk("hold_last",  64'(m_last), 64'(hold_l));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", m_data, 64'hDEAD_0000_0000_DEAD);
            end else begin
               mon_w = exp_q.pop_front();
               chk("m_data", m_data, mon_w.data);
               chk("m_keep", 64'(m_keep), 64'(mon_w.keep));
               chk("m_last", 64'(m_last), 64'(mon_w.last));
            end
         end
         hold_v = m_valid && !m_ready;
         hold_d = m_data; hold_k = m_keep; hold_l = m_last;
      end else begin
         hold_v = 0;
      end
   end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_data"},  m_data, 64'd0);
      chk({tag, "_m_keep"},  64'(m_keep), 64'd0);
      chk({tag, "_m_last"},  64'(m_last), 64'd0);
      chk({tag, "_err_bpt"}, 64'(err_bpt), 64'd0);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus
   initial begin
      int k;
      int mode;
      logic lst, lpk;
      aresetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_last_pkt = 1'b0;
      s_bytes_per_transfer = '0; m_ready = 1'b1;
      model_reset();
      @(posedge aclk); #1;
      chk_zero_outputs("reset");
      aresetn = 1'b1;

      // 1: two full words, packet end on the second
      send(mk(32'h1, 32'h2, 32'h3, 32'h4), 1'b0, 1'b0, 16'h0);
      send(mk(32'h5, 32'h6, 32'h7, 32'h8), 1'b0, 1'b0, 16'h0);
      send(mk(32'h9, 32'ha, 32'hb, 32'hc), 1'b0, 1'b0, 16'h0);
      send(mk(32'hd, 32'he, 32'hf, 32'h10), 1'b1, 1'b1, 16'd16);
      drain();

      // 2: three beats, partial flush on transfer end
      send(mk(32'h1, 32'h2, 32'h3, 32'h4), 1'b0, 1'b0, 16'h0);
      send(mk(32'h5, 32'h6, 32'h7, 32'h8), 1'b0, 1'b0, 16'h0);
      send(mk(32'h9, 32'ha, 32'hb, 32'hc), 1'b1, 1'b0, 16'd12);
      drain();

      // 3: scenario 1 with downstream stalled 5 cycles after the first word
      m_ready = 1'b0;
      send(mk(32'h1, 32'h2, 32'h3, 32'h4), 1'b0, 1'b0, 16'h0);
      send(mk(32'h5, 32'h6, 32'h7, 32'h8), 1'b0, 1'b0, 16'h0);
      fork
         begin
            send(mk(32'h9, 32'ha, 32'hb, 32'hc), 1'b0, 1'b0, 16'h0);
            send(mk(32'hd, 32'he, 32'hf, 32'h10), 1'b1, 1'b1, 16'd16);
         end
         begin
            for (int c = 0; c < 5; c++) begin
               @(negedge aclk);
               chk("stall_s_ready", 64'(s_ready), 64'd0);
               chk("stall_m_valid", 64'(m_valid), 64'd1);
            end
            @(posedge aclk); #1;
            m_ready = 1'b1;
         end
      join
      drain();

      // 5: truncation of large and negative rows
      send(mk(32'h000001A5, 32'hFFFFFF80, 32'h12345678, 32'h7FFFFFFF), 1'b1, 1'b0, 16'd4);
      send(mk(32'hFFFFFFFF, 32'h00000100, 32'h800000C3, 32'hAAAA5555), 1'b0, 1'b0, 16'h0);
      send(mk(32'h00000000, 32'hFFFFFF01, 32'h0000007F, 32'h80808080), 1'b1, 1'b1, 16'd8);
      drain();

      // randomized transfers with random backpressure and end-marker mix
      rdy_rand = 1;
      for (int x = 0; x < 60; x++) begin
         k = $urandom_range(1, 5);
         for (int b = 0; b < k; b++) begin
            lst = 1'b0; lpk = 1'b0;
            if (b == k - 1) begin
               mode = $urandom_range(0, 2);
               lst = (mode != 2);
               lpk = (mode != 0);
            end
            send({$urandom, $urandom, $urandom, $urandom}, lst, lpk,
                 (b == k - 1) ? 16'(k * BPB) : 16'($urandom));
         end
      end
      drain();

      // 4: byte-count mismatch is sticky across later good transfers
      send(mk(32'h11, 32'h22, 32'h33, 32'h44), 1'b0, 1'b0, 16'h0);
      send(mk(32'h55, 32'h66, 32'h77, 32'h88), 1'b0, 1'b0, 16'h0);
      send(mk(32'h99, 32'haa, 32'hbb, 32'hcc), 1'b1, 1'b0, 16'd16);
      @(negedge aclk);
      chk("err_set", 64'(err_bpt), 64'd1);
      @(posedge aclk); #1;
      send(mk(32'h1, 32'h2, 32'h3, 32'h4), 1'b0, 1'b0, 16'h0);
      send(mk(32'h5, 32'h6, 32'h7, 32'h8), 1'b1, 1'b1, 16'd8);
      drain();
      chk("err_sticky", 64'(err_bpt), 64'd1);

      // 6: async reset mid-word discards the partial beat
      send(mk(32'hAA, 32'hBB, 32'hCC, 32'hDD), 1'b0, 1'b0, 16'h0);
      aresetn = 1'b0;
      model_reset();
      #1;
      chk_zero_outputs("midreset");
      @(posedge aclk); #1;
      aresetn = 1'b1;
      send(mk(32'h21, 32'h22, 32'h23, 32'h24), 1'b0, 1'b0, 16'h0);
      send(mk(32'h25, 32'h26, 32'h27, 32'h28), 1'b1, 1'b1, 16'd8);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
